// File: rtl/codificador_instruccion.sv
// -----------------------------------------------------------------------------
// codificador_instruccion
//
// Packs decoded RV32I fields (format, opcode, registers, function fields and a
// full-width constant) into a 32-bit instruction word. It flags constants that
// do not fit the selected format and formats that do not exist. The datapath is
// a two-stage valid/ready pipeline: S1 holds the raw fields and S2 holds the
// encoded word. Two saturating counters track output transfers and erroneous
// output transfers.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   in_valid        in   input fields valid this cycle
//   in_ready        out  block can accept input (combinational from out_ready)
//   formato         in   3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   opcode          in   7  instruction bits [6:0]
//   rd, rs1, rs2    in   5  register indices
//   funct3          in   3  function field
//   funct7          in   7  function field
//   constante       in   32 immediate (byte offset for B/J, pre-shifted for U)
//   out_valid       out  instruccion is valid
//   out_ready       in   consumer accepts
//   instruccion     out  32 encoded instruction word
//   error_rango     out  constant out of range, or illegal format
//   contador_instr  out  16 saturating count of output transfers
//   contador_error  out  8  saturating count of erroneous output transfers
// -----------------------------------------------------------------------------
module codificador_instruccion (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  formato,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] constante,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruccion,
  output logic        error_rango,
  output logic [15:0] contador_instr,
  output logic [7:0]  contador_error
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } formato_e;

  typedef struct packed {
    logic [2:0]  formato;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] constante;
  } campos_t;

  // Stage 1: raw fields
  logic    s1_valid;
  campos_t s1;

  // Stage 2: encoded word
  logic    s2_valid;

  // Handshake. S2 can take a new entry when it is empty or draining this
  // cycle; S1 can take one when it is empty or its entry moves into S2.
  logic s2_load;
  logic out_fire;

  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_load;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Encoder and range check on the S1 contents
  // ---------------------------------------------------------------------------
  logic [31:0] c;
  logic [31:0] enc_instr;
  logic        enc_err;

  assign c = s1.constante;

  // NOTE: every output of this block is given a default before the case, so
  // no path through it leaves a value unassigned and no latch is inferred.
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (s1.formato)
      FMT_R: begin
        enc_instr = {s1.funct7, s1.rs2, s1.rs1, s1.funct3, s1.rd, s1.opcode};
      end
      FMT_I: begin
        enc_instr = {c[11:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
        // Sign-extended 12-bit value: bits 31..11 must all match.
        enc_err   = !((&c[31:11]) || !(|c[31:11]));
      end
      FMT_S: begin
        enc_instr = {c[11:5], s1.rs2, s1.rs1, s1.funct3, c[4:0], s1.opcode};
        enc_err   = !((&c[31:11]) || !(|c[31:11]));
      end
      FMT_B: begin
        enc_instr = {c[12], c[10:5], s1.rs2, s1.rs1, s1.funct3, c[4:1], c[11],
                     s1.opcode};
        // 13-bit signed even offset; bit 0 is not encodable.
        enc_err   = !((&c[31:12]) || !(|c[31:12])) || c[0];
      end
      FMT_U: begin
        enc_instr = {c[31:12], s1.rd, s1.opcode};
        enc_err   = |c[11:0];
      end
      FMT_J: begin
        enc_instr = {c[20], c[10:1], c[11], c[19:12], s1.rd, s1.opcode};
        // 21-bit signed even offset.
        enc_err   = !((&c[31:20]) || !(|c[31:20])) || c[0];
      end
      default: begin
        enc_instr = '0;
        enc_err   = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 1 register
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so that every
  // register samples the pre-edge values of the others, whatever the order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1 <= '{formato:   formato,
                opcode:    opcode,
                rd:        rd,
                rs1:       rs1,
                rs2:       rs2,
                funct3:    funct3,
                funct7:    funct7,
                constante: constante};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 register: holds while out_valid=1 and out_ready=0
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid    <= 1'b0;
      instruccion <= '0;
      error_rango <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        instruccion <= enc_instr;
        error_rango <= enc_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating transfer counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      contador_instr <= '0;
      contador_error <= '0;
    end else if (out_fire) begin
      if (contador_instr != 16'hFFFF) contador_instr <= contador_instr + 16'd1;
      if (error_rango && (contador_error != 8'hFF))
        contador_error <= contador_error + 8'd1;
    end
  end

endmodule

// File: doc/codificador_instruccion.md
CODIFICADOR_INSTRUCCION -- requirements
Module: codificador_instruccion

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 in_valid  in  1  input fields valid this cycle.
REQ-005 in_ready  out  1  block can accept input; a transfer occurs when in_valid=1 and in_ready=1 at a clk edge.
REQ-006 formato  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-007 opcode  in  7  instruction bits [6:0], passed through unchanged.
REQ-008 rd, rs1, rs2  in  5 each  register indices.
REQ-009 funct3  in  3; funct7  in  7  function fields.
REQ-010 constante  in  32  full-width immediate value, byte offset for B/J, already shifted value for U.
REQ-011 out_valid  out  1  instruccion is valid.
REQ-012 out_ready  in  1  consumer accepts; a transfer occurs when out_valid=1 and out_ready=1.
REQ-013 instruccion  out  32  encoded RV32I instruction word.
REQ-014 error_rango  out  1  qualifies instruccion; constante was not representable, or formato was illegal.
REQ-015 contador_instr  out  16  count of output transfers.
REQ-016 contador_error  out  8  count of output transfers with error_rango=1.

Function
REQ-017 Encoding SHALL be as follows:
- R: funct7, rs2, rs1, funct3, rd, opcode.
- I: c[11:0], rs1, funct3, rd, opcode.
- S: c[11:5], rs2, rs1, funct3, c[4:0], opcode.
- B: c[12], c[10:5], rs2, rs1, funct3, c[4:1], c[11], opcode.
- U: c[31:12], rd, opcode.
- J: c[20], c[10:1], c[11], c[19:12], rd, opcode.
- c = constante.
REQ-018 Range check SHALL flag error_rango=1 when any of these holds:
- I or S: c[31:11] is not all-equal.
- B: c[31:12] is not all-equal, or c[0]=1.
- U: c[11:0]!=0.
- J: c[31:20] is not all-equal, or c[0]=1.
- formato is 6 or 7.
REQ-019 R format SHALL never flag error_rango.
REQ-020 An erroneous entry SHALL still be emitted, with the immediate truncated per REQ-017; for illegal formato, instruccion SHALL be 32'h0.
REQ-021 The datapath SHALL be a 2-stage pipeline:
- S1 registers the input fields.
- S2 registers instruccion and error_rango.
- Each stage holds a valid bit.
REQ-022 Latency from input transfer to out_valid=1 SHALL be 2 cycles when there is no backpressure.
REQ-023 S2 SHALL load from S1 when S2 is empty or is transferring this cycle; otherwise S2 SHALL hold.
REQ-024 in_ready SHALL equal (!S1 valid) OR (S1 advancing into S2) in the same cycle; this is a combinational path from out_ready.
REQ-025 Sustained throughput SHALL be 1 instruction per cycle when out_ready=1.
REQ-026 Ordering SHALL be strict FIFO; no entry is dropped or duplicated.
REQ-027 With out_ready=0, exactly 2 entries SHALL be buffered, after which in_ready=0.
REQ-028 instruccion and error_rango SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 contador_instr SHALL increment by 1 per output transfer and saturate at 16'hFFFF.
REQ-030 contador_error SHALL increment on each output transfer with error_rango=1 and saturate at 8'hFF.
REQ-031 On simultaneous input and output transfer, the pipeline SHALL advance with no bubble.

Reset
REQ-032 On reset assertion the block SHALL, without waiting for clk:
- drive out_valid=0, instruccion=0, error_rango=0;
- clear contador_instr and contador_error to 0;
- clear both stage valid bits.
REQ-033 Entries in flight at reset SHALL be discarded.
REQ-034 in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-035 I-type, out_ready=1: opcode=7'b0010011, rd=1, rs1=2, funct3=0, constante=32'hFFFFFFFF -> instruccion=32'hFFF10093, error_rango=0, out_valid exactly 2 cycles after the input transfer.
REQ-036 S then B, back-to-back:
- S: opcode=7'b0100011, funct3=3'b010, rs1=2, rs2=5, constante=8 -> 32'h00512423.
- B: opcode=7'b1100011, rs1=rs2=0, funct3=0, constante=32'hFFFFFFFC -> 32'hFE000EE3.
- The two outputs appear on consecutive cycles.
REQ-037 I-type with opcode=7'b0010011, all register and function fields 0, constante=32'h00000800 -> instruccion=32'h80000013, error_rango=1, contador_error=1.
REQ-038 Backpressure: out_ready=0 while offering 3 entries -> 2 accepted, then in_ready=0; set out_ready=1 -> all 3 emitted in order; contador_instr=3.
REQ-039 Reset mid-operation: assert reset with 2 entries buffered -> out_valid=0 and counters=0 immediately; nothing is emitted after reset deasserts.
REQ-040 Illegal formato=7 -> instruccion=0, error_rango=1.
